serial_prefetcher: RTL

SERIAL_PREFETCHER -- requirements
Module: serial_prefetcher

---
 rtl/prefetch_pkg.sv | 32 +++
 rtl/prefetch_fifo.sv | 59 +++++
 rtl/serial_prefetcher.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// ============================================================================
// Module   : prefetch_pkg
// Brief    : Shared constants and width helpers for the serial prefetcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prefetch_pkg;

    // Opcode of the serial read transaction issued by the link controller.
    localparam logic [7:0] READ_CMD = 8'h03;

    function automatic int word_width(input int io_bits, input int cycles);
        return io_bits * cycles;
    endfunction

    function automatic int addr_step(input int w);
        return w / 8;
    endfunction

    // Credits reach DEPTH+1 (full queue plus the word held in inst).
    function automatic int credit_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// Module   : prefetch_fifo
// Brief    : Circular word queue with synchronous clear and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW   = ptr_width(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CNTW-1:0] count_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            // The credit scheme upstream must make a push into a full queue impossible.
            if (push && !pop) assert (count_q != CNTW'(DEPTH));
            if (push) wr_q <= bump(wr_q);
            if (pop)  rd_q <= bump(rd_q);
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/serial_prefetcher.sv
// ============================================================================
// Module   : serial_prefetcher
// Brief    : Credit-based instruction prefetcher over a serial read link.
//            Optional stall counter port under SERIAL_PREFETCHER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_prefetcher
    import prefetch_pkg::*;
#(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int DEPTH          = 2,
    parameter logic [IO_BITS*PAYLOAD_CYCLES-1:0] RESET_PC = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [IO_BITS*PAYLOAD_CYCLES-1:0] inst,
    output logic                              inst_valid,
    input  logic                              inst_done,
    input  logic                              jump,
    input  logic [IO_BITS*PAYLOAD_CYCLES-1:0] jump_target,
    output logic                              tx_command_valid,
    input  logic                              tx_command_started,
    output logic [IO_BITS-1:0]                tx_data,
    input  logic                              tx_data_next,
    input  logic                              rx_data_valid,
    input  logic [IO_BITS-1:0]                rx_pins,
    input  logic                              rx_done
`ifdef SERIAL_PREFETCHER_PERF_EN
    ,
    output logic [15:0]                       stall_cycles
`endif
);

    localparam int W   = word_width(IO_BITS, PAYLOAD_CYCLES);
    localparam int CW  = credit_width(DEPTH);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam logic [W-1:0] PC_STEP    = W'(addr_step(W));
    localparam logic [CW:0]  CREDIT_MAX = (CW + 1)'(DEPTH + 1);

    logic [W-1:0]         pc_q, pc_d;
    logic [W-1:0]         addr_sreg_q;
    logic [W-IO_BITS-1:0] rx_sreg_q;
    logic [W-1:0]         inst_q, inst_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        num_flushed_q, num_flushed_d;

    logic [W-1:0]   rx_word;
    logic           word_done, flush_word, keep_word;
    logic           consume, slot_free, fifo_empty;
    logic           fifo_push, fifo_pop, fifo_clear;
    logic [W-1:0]   fifo_head;
    logic [FCW-1:0] fifo_count;
    logic [CW:0]    credits;

    assign rx_word    = {rx_pins, rx_sreg_q};
    assign word_done  = rx_data_valid && rx_done;
    assign flush_word = word_done && (num_flushed_q != '0);
    assign keep_word  = word_done && !flush_word;
    assign consume    = inst_valid_q && inst_done;
    assign slot_free  = !inst_valid_q || consume;
    assign fifo_empty = (fifo_count == '0);

    assign credits = {1'b0, inflight_q} + (CW + 1)'(fifo_count) + (CW + 1)'(inst_valid_q);
    assign tx_command_valid = !reset && !jump && (credits < CREDIT_MAX);

    always_comb begin
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_valid_d  = inst_valid_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_clear    = 1'b0;
        inflight_d    = inflight_q + CW'(tx_command_started);
        // A stray completion with nothing outstanding (link reset skew) must not underflow.
        if (word_done && (inflight_d != '0)) inflight_d = inflight_d - 1'b1;
        num_flushed_d = num_flushed_q - CW'(flush_word);

        if (jump) begin
            pc_d          = jump_target;
            fifo_clear    = 1'b1;
            inst_valid_d  = 1'b0;
            num_flushed_d = inflight_d;
        end else begin
            if (tx_command_started) pc_d = pc_q + PC_STEP;
            if (slot_free && !fifo_empty) begin
                inst_d       = fifo_head;
                inst_valid_d = 1'b1;
                fifo_pop     = 1'b1;
                fifo_push    = keep_word;
            end else if (slot_free && keep_word) begin
                inst_d       = rx_word;
                inst_valid_d = 1'b1;
            end else begin
                fifo_push = keep_word;
                if (consume) inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            addr_sreg_q   <= '0;
            rx_sreg_q     <= '0;
            inst_q        <= '0;
            inst_valid_q  <= 1'b0;
            inflight_q    <= '0;
            num_flushed_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_valid_q  <= inst_valid_d;
            inflight_q    <= inflight_d;
            num_flushed_q <= num_flushed_d;
            if (tx_command_started)  addr_sreg_q <= pc_q;
            else if (tx_data_next)   addr_sreg_q <= addr_sreg_q >> IO_BITS;
            if (rx_data_valid)       rx_sreg_q   <= rx_word[W-1:IO_BITS];
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .din   (rx_word),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign tx_data    = addr_sreg_q[IO_BITS-1:0];

`ifdef SERIAL_PREFETCHER_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)                                 stall_q <= '0;
        else if (!inst_valid_q && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire
